mem_arbiter: RTL and testbench

- Shares the single unified instruction/data memory between two requesters: requester 0 is the core (fetch, load and store), and requester 1 is the debug/program loader.
- Sequences each access through a 3-state FSM with a valid/ready request handshake and a one-cycle response strobe.
- Sits between the core's memory interface and the memory array, replacing the core's direct connection.
- The debug lock lets the loader stall the core while it writes a program into memory.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/rr_picker.sv | 23 ++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Requester 0 is the core, requester 1 is the debug/program loader.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } arb_state_t;

  localparam int NUM_REQ  = 2;
  localparam int REQ_CORE = 0;
  localparam int REQ_DBG  = 1;

  function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
    logic [NUM_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational 2-way winner selection.
// Ties go to the requester that did not win last, unless FIXED_PRIORITY makes index 0 win.
module rr_picker #(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic [1:0] eligible,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |eligible;
    grant_idx   = 1'b0;
    case (eligible)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant;
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single unified memory between the core and the debug loader.
// Each access runs IDLE -> ACCESS -> RESPOND, with a one-cycle response strobe.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                req_valid,
  input  logic [1:0]                req_we,
  input  logic [2*ADDR_WIDTH-1:0]   req_addr,
  input  logic [2*DATA_WIDTH-1:0]   req_wdata,
  input  logic [2*(DATA_WIDTH/8)-1:0] req_wstrb,
  output logic [1:0]                req_ready,
  output logic [1:0]                rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  input  logic                      dbg_lock,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      busy
);

  localparam int STRB_W = DATA_WIDTH / 8;

  arb_state_t state;
  logic       cur;
  logic       cur_we;
  logic       last_grant;

  logic [1:0] eligible;
  logic       win_valid;
  logic       win_idx;

  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_W-1:0]     sel_wstrb;

  // The lock only gates new core grants; an in-flight core access finishes.
  assign eligible[REQ_CORE] = req_valid[REQ_CORE] & ~dbg_lock;
  assign eligible[REQ_DBG]  = req_valid[REQ_DBG];

  rr_picker #(
    .FIXED_PRIORITY(FIXED_PRIORITY)
  ) u_picker (
    .eligible   (eligible),
    .last_grant (last_grant),
    .grant_valid(win_valid),
    .grant_idx  (win_idx)
  );

  assign sel_we    = win_idx ? req_we[REQ_DBG] : req_we[REQ_CORE];
  assign sel_addr  = win_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
  assign sel_wdata = win_idx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
  assign sel_wstrb = win_idx ? req_wstrb[2*STRB_W-1:STRB_W] : req_wstrb[STRB_W-1:0];

  always_comb begin
    req_ready = '0;
    if (state == IDLE && win_valid) begin
      req_ready = req_onehot(win_idx);
    end
  end

  // Read data arrives from the memory one cycle after mem_en, i.e. during RESPOND.
  always_comb begin
    rsp_rdata = '0;
    if (state == RESPOND && !cur_we) begin
      rsp_rdata = mem_rdata;
    end
  end

  // The mem_* registers double as the payload latch and are only non-zero in ACCESS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cur        <= 1'b0;
      cur_we     <= 1'b0;
      last_grant <= 1'b1;
      busy       <= 1'b0;
      rsp_valid  <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            state     <= ACCESS;
            busy      <= 1'b1;
            cur       <= win_idx;
            cur_we    <= sel_we;
            mem_en    <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_wstrb <= sel_we ? sel_wstrb : '0;
          end
        end
        ACCESS: begin
          state     <= RESPOND;
          rsp_valid <= req_onehot(cur);
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          mem_wstrb <= '0;
        end
        RESPOND: begin
          state      <= IDLE;
          busy       <= 1'b0;
          rsp_valid  <= '0;
          last_grant <= cur;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          rsp_valid <= '0;
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          mem_wstrb <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: scoreboarded responses plus cycle-exact handshake checks.
// A second instance with FIXED_PRIORITY=1 covers the fixed-priority tie rule.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [1:0]    req_valid, req_we, req_ready, rsp_valid;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [7:0]    req_wstrb;
  logic [DW-1:0] rsp_rdata, mem_wdata, mem_rdata;
  logic          dbg_lock, mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wstrb;

  logic [1:0]    fp_req_valid, fp_req_we, fp_req_ready, fp_rsp_valid;
  logic [2*AW-1:0] fp_req_addr;
  logic [2*DW-1:0] fp_req_wdata;
  logic [7:0]    fp_req_wstrb;
  logic [DW-1:0] fp_rsp_rdata, fp_mem_wdata, fp_mem_rdata;
  logic          fp_dbg_lock, fp_mem_en, fp_mem_we, fp_busy;
  logic [AW-1:0] fp_mem_addr;
  logic [3:0]    fp_mem_wstrb;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(0)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .dbg_lock(dbg_lock), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(1)) dut_fp (
    .clk(clk), .reset(reset), .req_valid(fp_req_valid), .req_we(fp_req_we), .req_addr(fp_req_addr),
    .req_wdata(fp_req_wdata), .req_wstrb(fp_req_wstrb), .req_ready(fp_req_ready),
    .rsp_valid(fp_rsp_valid), .rsp_rdata(fp_rsp_rdata), .dbg_lock(fp_dbg_lock),
    .mem_en(fp_mem_en), .mem_we(fp_mem_we), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata),
    .mem_wstrb(fp_mem_wstrb), .mem_rdata(fp_mem_rdata), .busy(fp_busy)
  );

  // Behavioural memory: byte-strobed writes, read data one cycle after mem_en.
  logic [31:0] ram [0:63];
  logic        preload_en;
  logic [5:0]  preload_idx;
  logic [31:0] preload_data;

  always @(posedge clk) begin
    if (preload_en) begin
      ram[preload_idx] <= preload_data;
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wstrb[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    mem_rdata <= (mem_en && !mem_we) ? ram[mem_addr[7:2]] : 32'h0;
  end

  always @(posedge clk) begin
    fp_mem_rdata <= fp_mem_en ? (fp_mem_addr ^ 32'hA5A5_0000) : 32'h0;
  end

  logic [31:0] ref_mem [0:63];

  typedef struct packed {
    logic [1:0]  who;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int r);
    return (r == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic go_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    preload_en   = 1'b1;
    preload_idx  = 6'(idx);
    preload_data = d;
    ref_mem[idx] = d;
    @(posedge clk);
    #1;
    preload_en = 1'b0;
  endtask

  task automatic set_req(input int r, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
    req_valid[r]           = 1'b1;
    req_we[r]              = we;
    req_addr[r*AW +: AW]   = addr;
    req_wdata[r*DW +: DW]  = wdata;
    req_wstrb[r*4 +: 4]    = strb;
  endtask

  // Scoreboard: every response strobe pops the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (reset && rsp_valid != 2'b00) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_rsp", 32'(rsp_valid), 32'h0);
      end else begin
        e = sb_q.pop_front();
        check("sb_rsp_id", 32'(rsp_valid), 32'(e.who));
        check("sb_rsp_data", rsp_rdata, e.data);
      end
    end
  end

  // One isolated transaction: grant in cycle N, access in N+1, response in N+2.
  task automatic do_txn(input int r, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb);
    go_cycle();
    set_req(r, we, addr, wdata, strb);
    settle();
    check("txn_ready", 32'(req_ready), 32'(oh(r)));
    check("txn_busy_idle", 32'(busy), 32'h0);
    if (we) begin
      sb_q.push_back('{who: oh(r), data: 32'h0});
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) ref_mem[addr[7:2]][8*b +: 8] = wdata[8*b +: 8];
      end
    end else begin
      sb_q.push_back('{who: oh(r), data: ref_mem[addr[7:2]]});
    end
    go_cycle();
    req_valid[r] = 1'b0;
    settle();
    check("txn_mem_en", 32'(mem_en), 32'h1);
    check("txn_mem_we", 32'(mem_we), 32'(we));
    check("txn_mem_addr", mem_addr, addr);
    check("txn_mem_wdata", mem_wdata, wdata);
    check("txn_mem_wstrb", 32'(mem_wstrb), we ? 32'(strb) : 32'h0);
    check("txn_ready_access", 32'(req_ready), 32'h0);
    check("txn_busy_access", 32'(busy), 32'h1);
    go_cycle();
    settle();
    check("txn_rsp_valid", 32'(rsp_valid), 32'(oh(r)));
    check("txn_mem_en_respond", 32'(mem_en), 32'h0);
  endtask

  // Transaction with requests held by the caller; optionally raises the lock during ACCESS.
  task automatic held_txn(input int exp_r, input logic [31:0] exp_addr, input logic set_lock);
    settle();
    check("held_ready", 32'(req_ready), 32'(oh(exp_r)));
    sb_q.push_back('{who: oh(exp_r), data: ref_mem[exp_addr[7:2]]});
    go_cycle();
    if (set_lock) dbg_lock = 1'b1;
    settle();
    check("held_mem_en", 32'(mem_en), 32'h1);
    check("held_mem_addr", mem_addr, exp_addr);
    check("held_ready_access", 32'(req_ready), 32'h0);
    go_cycle();
    settle();
    check("held_rsp_valid", 32'(rsp_valid), 32'(oh(exp_r)));
    go_cycle();
  endtask

  task automatic fp_txn(input int exp_r, input logic [31:0] exp_addr);
    settle();
    check("fp_ready", 32'(fp_req_ready), 32'(oh(exp_r)));
    go_cycle();
    settle();
    check("fp_mem_addr", fp_mem_addr, exp_addr);
    go_cycle();
    settle();
    check("fp_rsp_valid", 32'(fp_rsp_valid), 32'(oh(exp_r)));
    check("fp_rsp_rdata", fp_rsp_rdata, exp_addr ^ 32'hA5A5_0000);
    go_cycle();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    dbg_lock = 1'b0;
    fp_req_valid = '0; fp_req_we = '0; fp_req_addr = '0; fp_req_wdata = '0; fp_req_wstrb = '0;
    fp_dbg_lock = 1'b0;
    preload_en = 1'b0; preload_idx = '0; preload_data = '0;

    preload(0, 32'h0001_0093);
    preload(1, 32'h1234_5678);
    preload(2, 32'h0);
    settle();
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_mem_en", 32'(mem_en), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    go_cycle();
    reset = 1'b1;

    $display("[TB] single read, write, readback");
    do_txn(0, 1'b0, 32'h0, 32'h0, 4'h0);
    do_txn(1, 1'b1, 32'h8, 32'hff81_0093, 4'hF);
    do_txn(1, 1'b0, 32'h8, 32'h0, 4'h0);

    $display("[TB] round-robin contention");
    go_cycle();
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h4, 32'h0, 4'h0);
    held_txn(0, 32'h0, 1'b0);
    held_txn(1, 32'h4, 1'b0);
    held_txn(0, 32'h0, 1'b0);
    held_txn(1, 32'h4, 1'b0);

    $display("[TB] debug lock");
    dbg_lock = 1'b1;
    held_txn(1, 32'h4, 1'b0);
    held_txn(1, 32'h4, 1'b0);
    dbg_lock = 1'b0;
    held_txn(0, 32'h0, 1'b1);
    held_txn(1, 32'h4, 1'b0);
    req_valid = '0;
    dbg_lock  = 1'b0;

    $display("[TB] reset during ACCESS");
    set_req(0, 1'b0, 32'h4, 32'h0, 4'h0);
    settle();
    check("rstmid_ready", 32'(req_ready), 32'h1);
    go_cycle();
    req_valid = '0;
    settle();
    check("rstmid_pre_mem_en", 32'(mem_en), 32'h1);
    reset = 1'b0;
    #1;
    check("rstmid_busy", 32'(busy), 32'h0);
    check("rstmid_mem_en", 32'(mem_en), 32'h0);
    check("rstmid_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rstmid_mem_addr", mem_addr, 32'h0);
    go_cycle();
    settle();
    check("rstmid_no_rsp", 32'(rsp_valid), 32'h0);
    go_cycle();
    reset = 1'b1;
    do_txn(0, 1'b0, 32'h4, 32'h0, 4'h0);

    $display("[TB] fixed priority instance");
    go_cycle();
    fp_req_addr  = {32'h44, 32'h40};
    fp_req_valid = 2'b11;
    fp_txn(0, 32'h40);
    fp_txn(0, 32'h40);
    fp_txn(0, 32'h40);
    fp_req_valid[0] = 1'b0;
    fp_txn(1, 32'h44);
    fp_req_valid = '0;

    go_cycle();
    settle();
    check("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
